button_event_gen: RTL

Per-button input conditioner that sits directly upstream of vga_state_machine, one instance per board button (B2..B5).
- Synchronises the raw pad signal and debounces it.
- Emits single-cycle press, release and auto-repeat event pulses plus a stable level.
- The game FSM consumes clean, one-cycle events; the left/right paddle gets held-key repeat without extra logic in the FSM.

---
 rtl/button_event_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// Per-button input conditioner: two-flop synchroniser, debounce,
// single-cycle press/release/auto-repeat events and a debounced level.
`timescale 1ns/1ps
module button_event_gen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Polarity is normalised before the synchroniser so 1 always means pressed.
    logic btn_pad;
    assign btn_pad = ACTIVE_LOW ? ~btn_in : btn_in;

    logic             s1_reg, s2_reg;
    logic             btn_sync;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             btn_level_reg, btn_level_next;
    logic             press_pulse_reg, press_pulse_next;
    logic             release_pulse_reg, release_pulse_next;
    logic             repeat_pulse_reg, repeat_pulse_next;
    logic [7:0]       press_cnt_reg, press_cnt_next;
    logic             release_hit;

    assign btn_sync = s2_reg;

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= btn_pad;
            s2_reg <= s1_reg;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            deb_cnt_reg       <= '0;
            rpt_cnt_reg       <= '0;
            btn_level_reg     <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            repeat_pulse_reg  <= 1'b0;
            press_cnt_reg     <= 8'd0;
        end else begin
            state_reg         <= state_next;
            deb_cnt_reg       <= deb_cnt_next;
            rpt_cnt_reg       <= rpt_cnt_next;
            btn_level_reg     <= btn_level_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
            repeat_pulse_reg  <= repeat_pulse_next;
            press_cnt_reg     <= press_cnt_next;
        end
    end

    // Next-state logic: debounce in both directions, repeat timing while held.
    always_comb begin
        state_next         = state_reg;
        deb_cnt_next       = deb_cnt_reg;
        rpt_cnt_next       = rpt_cnt_reg;
        btn_level_next     = btn_level_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        repeat_pulse_next  = 1'b0;
        press_cnt_next     = press_cnt_reg;
        release_hit        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (btn_sync) begin
                    if (deb_cnt_reg == DEB_LAST) begin
                        state_next       = HELD;
                        btn_level_next   = 1'b1;
                        press_pulse_next = 1'b1;
                        press_cnt_next   = press_cnt_reg + 8'd1;
                        deb_cnt_next     = '0;
                        rpt_cnt_next     = '0;
                    end else begin
                        deb_cnt_next = deb_cnt_reg + CNT_ONE;
                    end
                end else begin
                    deb_cnt_next = '0;
                end
            end

            HELD, REPEAT: begin
                release_hit = !btn_sync && (deb_cnt_reg == DEB_LAST);
                if (release_hit) begin
                    // A qualified release overrides any repeat tick due now.
                    state_next         = IDLE;
                    btn_level_next     = 1'b0;
                    release_pulse_next = 1'b1;
                    deb_cnt_next       = '0;
                    rpt_cnt_next       = '0;
                end else begin
                    deb_cnt_next = btn_sync ? '0 : (deb_cnt_reg + CNT_ONE);
                    if (state_reg == HELD) begin
                        if (!repeat_en) begin
                            rpt_cnt_next = '0;
                        end else if (rpt_cnt_reg == DLY_LAST) begin
                            state_next        = REPEAT;
                            repeat_pulse_next = 1'b1;
                            rpt_cnt_next      = '0;
                        end else begin
                            rpt_cnt_next = rpt_cnt_reg + CNT_ONE;
                        end
                    end else begin
                        if (!repeat_en) begin
                            state_next   = HELD;
                            rpt_cnt_next = '0;
                        end else if (rpt_cnt_reg == PER_LAST) begin
                            repeat_pulse_next = 1'b1;
                            rpt_cnt_next      = '0;
                        end else begin
                            rpt_cnt_next = rpt_cnt_reg + CNT_ONE;
                        end
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                btn_level_next = 1'b0;
                deb_cnt_next   = '0;
                rpt_cnt_next   = '0;
            end
        endcase
    end

    assign btn_level     = btn_level_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign repeat_pulse  = repeat_pulse_reg;
    assign press_cnt     = press_cnt_reg;
    assign state_dbg     = state_reg;

endmodule
